// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and fetch FSM encoding for the CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int ADDR_W  = 16;
   localparam int HALF_W  = 16;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef enum logic [0:0] {
      FETCH_LO = 1'b0,
      FETCH_HI = 1'b1
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fifo
// Brief    : Synchronous FIFO of {pc, instr} entries; flush wins over push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [INSTR_W-1:0]     pushInstr,
   input  logic [ADDR_W-1:0]      pushPc,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [INSTR_W-1:0]     headInstr,
   output logic [ADDR_W-1:0]      headPc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [INSTR_W-1:0] r_instrMem [DEPTH];
   logic [ADDR_W-1:0]  r_pcMem    [DEPTH];
   logic [PTR_W-1:0]   r_rdPtr;
   logic [PTR_W-1:0]   r_wrPtr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Storage is cleared on reset so the head outputs read zero while held.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_instrMem[i] <= '0;
            r_pcMem[i]    <= '0;
         end
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_instrMem[r_wrPtr] <= pushInstr;
            r_pcMem[r_wrPtr]    <= pushPc;
            r_wrPtr             <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign headInstr = r_instrMem[r_rdPtr];
   assign headPc    = r_pcMem[r_rdPtr];

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Brief    : Two-halfword instruction fetcher feeding a small prefetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               rstN,
   output logic [ADDR_W-1:0]  memAddr,
   output logic               memRe,
   input  logic               memGnt,
   input  logic [HALF_W-1:0]  busD,
   output logic               instrValid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instrPc,
   input  logic               instrReady,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirectPc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_fetchPc;
   logic [HALF_W-1:0] r_loHalf;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic              w_memDone;
   logic              w_push;
   logic              w_pop;
   logic              w_unused;

   // A new instruction is only started when a slot is free, so the upper-half
   // completion can always push. rstN gates the request so reset drops it at once.
   assign memRe     = rstN && ((r_state == FETCH_HI) || !w_full);
   assign memAddr   = !memRe                ? '0 :
                      (r_state == FETCH_HI) ? r_fetchPc + ADDR_W'(HALF_W / 8) :
                                              r_fetchPc;
   assign w_memDone = memRe && memGnt;
   assign w_push    = w_memDone && (r_state == FETCH_HI) && !redirect;
   assign w_pop     = instrValid && instrReady && !redirect;
   assign w_unused  = ^{redirectPc[0], w_count};

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state   <= FETCH_LO;
         r_fetchPc <= RESET_PC;
         r_loHalf  <= '0;
      end else if (redirect) begin
         r_state   <= FETCH_LO;
         r_fetchPc <= {redirectPc[ADDR_W-1:1], 1'b0};
      end else if (w_memDone) begin
         case (r_state)
            FETCH_LO: begin
               r_loHalf <= busD;
               r_state  <= FETCH_HI;
            end
            FETCH_HI: begin
               r_fetchPc <= r_fetchPc + ADDR_W'(PC_STEP);
               r_state   <= FETCH_LO;
            end
            default: r_state <= FETCH_LO;
         endcase
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstN      (rstN),
      .push      (w_push),
      .pop       (w_pop),
      .flush     (redirect),
      .pushInstr ({busD, r_loHalf}),
      .pushPc    (r_fetchPc),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count),
      .headInstr (instr),
      .headPc    (instrPc)
   );

   assign instrValid = !w_empty;

endmodule
`default_nettype wire
